pong_compositor: RTL and testbench

Parametrised pixel compositor, successor to the fixed three-sprite white-on-black renderer.
- Merges N sprite hit flags, one overlay flag (net/scoreboard) and one text flag into multi-bit RGB, with per-sprite colour and fixed priority.
- Adds frame-synchronised mode switching, a text blink and a dimmed pause mode.
- Sits between the sprite/text hit generators and the VGA DAC pins.

---
 rtl/pong_pkg.sv | 25 ++
 rtl/pong_frame_timer.sv | 75 +++++++
 rtl/pong_compositor.sv | 156 +++++++++++++++
 tb/tb_pong_compositor.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared definitions for the pong compositor: screen modes, colour
// constants and the sprite-pair index used by the collision vector.
package pong_pkg;

  typedef enum logic [1:0] {
    MODE_STARTUP = 2'd0,
    MODE_PLAY    = 2'd1,
    MODE_OVER    = 2'd2,
    MODE_PAUSE   = 2'd3
  } mode_e;

  localparam int COLOR_BITS_DEFAULT = 4;

  // Wide enough for any sensible channel depth; users slice the low 3*COLOR_BITS.
  localparam int MAX_COLOR_BITS = 16;
  localparam logic [3*MAX_COLOR_BITS-1:0] WHITE = '1;
  localparam logic [3*MAX_COLOR_BITS-1:0] BLACK = '0;

  // Flat index of sprite pair (i,j), i<j, out of n sprites:
  // (0,1)=0, (0,2)=1, ... (0,n-1), (1,2), ...
  function automatic int pair_index(input int i, input int j, input int n);
    return (i * (2 * n - i - 1)) / 2 + (j - i - 1);
  endfunction

endpackage

// File: rtl/pong_frame_timer.sv
// Frame timing for the compositor: detects the first blanking line, emits a
// one-cycle frame_tick, latches the requested screen mode only at frame
// boundaries and runs the text blink counter.
//
// mode_active state | meaning
// ------------------+---------------------------------------------
// MODE_STARTUP      | title screen, only text is drawn (reset state)
// MODE_PLAY         | sprites, then overlay, full intensity
// MODE_OVER         | game-over screen, only text is drawn
// MODE_PAUSE        | play picture at half intensity, blinking text
module pong_frame_timer
  import pong_pkg::*;
#(
  parameter int V_VIDEO      = 480,
  parameter int BLINK_FRAMES = 30
) (
  input  logic       clk_0,
  input  logic       rst,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic [1:0] mode_req,
  output logic       frame_tick,
  output logic [1:0] mode_active,
  output logic       blink
);

  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  logic             frame_tick_d, frame_tick_q;
  mode_e            mode_d, mode_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             blink_d, blink_q;

  // Next-state: boundary detect, mode latch and blink counter (all advance on the tick).
  always_comb begin
    frame_tick_d = (pixel_x == 10'd0) && (pixel_y == 10'(V_VIDEO));
    mode_d       = mode_q;
    cnt_d        = cnt_q;
    blink_d      = blink_q;
    if (frame_tick_q) begin
      mode_d = mode_e'(mode_req);
      if (mode_d != mode_q) begin
        // a new mode always starts its blink from a clean phase
        cnt_d   = '0;
        blink_d = 1'b0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        blink_d = ~blink_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_0) begin
    if (!rst) begin
      frame_tick_q <= 1'b0;
      mode_q       <= MODE_STARTUP;
      cnt_q        <= '0;
      blink_q      <= 1'b0;
    end else begin
      frame_tick_q <= frame_tick_d;
      mode_q       <= mode_d;
      cnt_q        <= cnt_d;
      blink_q      <= blink_d;
    end
  end

  assign frame_tick  = frame_tick_q;
  assign mode_active = mode_q;
  assign blink       = blink_q;

endmodule

// File: rtl/pong_compositor.sv
// Pixel compositor: merges sprite, overlay and text hit flags into RGB via a
// two-stage pipeline (S1 registers the hit flags, S2 picks and registers the
// colour). Mode and blink come from pong_frame_timer.
// Optional macro COMPOSITOR_COLLISION_EN adds a per-frame sprite-pair
// collision vector.
module pong_compositor
  import pong_pkg::*;
#(
  parameter int NUM_SPRITES  = 4,
  parameter int COLOR_BITS   = COLOR_BITS_DEFAULT,
  parameter int V_VIDEO      = 480,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                                clk_0,
  input  logic                                rst,
  input  logic [9:0]                          pixel_x,
  input  logic [9:0]                          pixel_y,
  input  logic                                video_on,
  input  logic [NUM_SPRITES-1:0]              sprite_hit,
  input  logic [NUM_SPRITES-1:0]              sprite_en,
  input  logic [NUM_SPRITES*3*COLOR_BITS-1:0] sprite_color,
  input  logic                                overlay_hit,
  input  logic                                text_hit,
  input  logic [1:0]                          mode_req,
  output logic [COLOR_BITS-1:0]               red,
  output logic [COLOR_BITS-1:0]               green,
  output logic [COLOR_BITS-1:0]               blue,
  output logic [1:0]                          mode_active,
  output logic                                frame_tick,
  output logic                                blink
`ifdef COMPOSITOR_COLLISION_EN
  ,
  output logic [NUM_SPRITES*(NUM_SPRITES-1)/2-1:0] collision
`endif
);

  localparam int RGB_W = 3 * COLOR_BITS;
  localparam logic [RGB_W-1:0] RGB_WHITE = WHITE[RGB_W-1:0];
  localparam logic [RGB_W-1:0] RGB_BLACK = BLACK[RGB_W-1:0];

  pong_frame_timer #(
    .V_VIDEO      (V_VIDEO),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_frame_timer (
    .clk_0       (clk_0),
    .rst         (rst),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .mode_req    (mode_req),
    .frame_tick  (frame_tick),
    .mode_active (mode_active),
    .blink       (blink)
  );

  logic [NUM_SPRITES-1:0] hit_s1_d, hit_s1_q;
  logic                   overlay_s1_d, overlay_s1_q;
  logic                   text_s1_d, text_s1_q;
  logic                   video_on_s1_d, video_on_s1_q;
  logic [RGB_W-1:0]       play_rgb, dim_rgb;
  logic [RGB_W-1:0]       rgb_d, rgb_q;

  // S1 inputs: disabled sprites are masked before they reach the pipeline.
  always_comb begin
    hit_s1_d      = sprite_hit & sprite_en;
    overlay_s1_d  = overlay_hit;
    text_s1_d     = text_hit;
    video_on_s1_d = video_on;
  end

  // PLAY picture: lowest-index sprite wins, then overlay, then background.
  always_comb begin
    play_rgb = overlay_s1_q ? RGB_WHITE : RGB_BLACK;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (hit_s1_q[i]) play_rgb = sprite_color[i*RGB_W +: RGB_W];
    end
  end

  // Half-intensity copy of the PLAY picture for PAUSE, per channel.
  always_comb begin
    dim_rgb = '0;
    for (int c = 0; c < 3; c++) begin
      dim_rgb[c*COLOR_BITS +: COLOR_BITS] = play_rgb[c*COLOR_BITS +: COLOR_BITS] >> 1;
    end
  end

  // S2 colour select by applied mode; blanking always forces black.
  always_comb begin
    case (mode_active)
      MODE_PLAY:  rgb_d = play_rgb;
      MODE_PAUSE: rgb_d = (text_s1_q && blink) ? RGB_WHITE : dim_rgb;
      default:    rgb_d = text_s1_q ? RGB_WHITE : RGB_BLACK;
    endcase
    if (!video_on_s1_q) rgb_d = RGB_BLACK;
  end

  // Pipeline registers with synchronous active-low reset.
  always_ff @(posedge clk_0) begin
    if (!rst) begin
      hit_s1_q      <= '0;
      overlay_s1_q  <= 1'b0;
      text_s1_q     <= 1'b0;
      video_on_s1_q <= 1'b0;
      rgb_q         <= '0;
    end else begin
      hit_s1_q      <= hit_s1_d;
      overlay_s1_q  <= overlay_s1_d;
      text_s1_q     <= text_s1_d;
      video_on_s1_q <= video_on_s1_d;
      rgb_q         <= rgb_d;
    end
  end

  assign red   = rgb_q[RGB_W-1 -: COLOR_BITS];
  assign green = rgb_q[2*COLOR_BITS-1 -: COLOR_BITS];
  assign blue  = rgb_q[COLOR_BITS-1:0];

`ifdef COMPOSITOR_COLLISION_EN
  localparam int NUM_PAIRS = NUM_SPRITES * (NUM_SPRITES - 1) / 2;

  logic [NUM_PAIRS-1:0] pair_now;
  logic [NUM_PAIRS-1:0] sticky_d, sticky_q;
  logic [NUM_PAIRS-1:0] collision_d, collision_q;

  for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : g_pair_i
    for (genvar gj = gi + 1; gj < NUM_SPRITES; gj++) begin : g_pair_j
      assign pair_now[pair_index(gi, gj, NUM_SPRITES)] =
        video_on_s1_q & hit_s1_q[gi] & hit_s1_q[gj];
    end
  end

  // Accumulate overlaps over a frame; publish and restart on the tick. The
  // pixel in S1 during the tick is already blanking of the next frame.
  always_comb begin
    sticky_d    = sticky_q | pair_now;
    collision_d = collision_q;
    if (frame_tick) begin
      collision_d = sticky_q;
      sticky_d    = pair_now;
    end
  end

  // Collision registers with synchronous active-low reset.
  always_ff @(posedge clk_0) begin
    if (!rst) begin
      sticky_q    <= '0;
      collision_q <= '0;
    end else begin
      sticky_q    <= sticky_d;
      collision_q <= collision_d;
    end
  end

  assign collision = collision_q;
`endif

endmodule

// File: tb/tb_pong_compositor.sv
// Directed self-checking bench for pong_compositor (BLINK_FRAMES=2).
module tb_pong_compositor;

  localparam int NS = 4;
  localparam int CB = 4;
  localparam int VV = 480;
  localparam int BF = 2;

  localparam logic [1:0] M_STARTUP = 2'd0;
  localparam logic [1:0] M_PLAY    = 2'd1;
  localparam logic [1:0] M_OVER    = 2'd2;
  localparam logic [1:0] M_PAUSE   = 2'd3;

  localparam logic [11:0] C0 = 12'hE62;
  localparam logic [11:0] C1 = 12'h123;
  localparam logic [11:0] C2 = 12'hF82;
  localparam logic [11:0] C3 = 12'h5AC;

  logic            clk_0 = 1'b0;
  logic            rst;
  logic [9:0]      pixel_x, pixel_y;
  logic            video_on;
  logic [NS-1:0]   sprite_hit, sprite_en;
  logic [NS*3*CB-1:0] sprite_color;
  logic            overlay_hit, text_hit;
  logic [1:0]      mode_req;
  logic [CB-1:0]   red, green, blue;
  logic [1:0]      mode_active;
  logic            frame_tick, blink;
`ifdef COMPOSITOR_COLLISION_EN
  logic [5:0]      collision;
`endif
  logic [11:0]     rgb;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk_0 = ~clk_0;
  assign rgb = {red, green, blue};

  pong_compositor #(
    .NUM_SPRITES  (NS),
    .COLOR_BITS   (CB),
    .V_VIDEO      (VV),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk_0        (clk_0),
    .rst          (rst),
    .pixel_x      (pixel_x),
    .pixel_y      (pixel_y),
    .video_on     (video_on),
    .sprite_hit   (sprite_hit),
    .sprite_en    (sprite_en),
    .sprite_color (sprite_color),
    .overlay_hit  (overlay_hit),
    .text_hit     (text_hit),
    .mode_req     (mode_req),
    .red          (red),
    .green        (green),
    .blue         (blue),
    .mode_active  (mode_active),
    .frame_tick   (frame_tick),
    .blink        (blink)
`ifdef COMPOSITOR_COLLISION_EN
    ,
    .collision    (collision)
`endif
  );

  // PLAY priority vectors: hit, enable, overlay, text -> expected RGB
  localparam logic [3:0]  PV_HIT [6] = '{4'b0100, 4'b1111, 4'b1000, 4'b0000, 4'b1100, 4'b0110};
  localparam logic [3:0]  PV_EN  [6] = '{4'b1011, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1101};
  localparam logic        PV_OV  [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam logic        PV_TX  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam logic [11:0] PV_EXP [6] = '{12'hFFF, C0, C3, 12'h000, C2, C2};

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_0);
      #1;
    end
  endtask

  task automatic set_pix(input int x, input int y, input logic v);
    pixel_x  = 10'(x);
    pixel_y  = 10'(y);
    video_on = v;
  endtask

  // Presents the boundary pixel for one cycle, then lets the new mode/blink
  // reach the output through the pipeline.
  task automatic frame_boundary();
    set_pix(0, VV, 1'b0);
    step(1);
    set_pix(10, 10, 1'b1);
    step(3);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    mode_req = M_PLAY;
    sprite_hit = '1;
    sprite_en = '1;
    overlay_hit = 1'b1;
    text_hit = 1'b1;
    sprite_color = {C3, C2, C1, C0};
    set_pix(0, VV, 1'b1);
    step(3);
    vec_cnt++;
    if (rgb !== 12'h000) begin err_cnt++; $display("FAIL reset_rgb: got %h expected %h", rgb, 12'h000); end
    vec_cnt++;
    if (frame_tick !== 1'b0) begin err_cnt++; $display("FAIL reset_tick: got %b expected 0", frame_tick); end
    vec_cnt++;
    if (blink !== 1'b0) begin err_cnt++; $display("FAIL reset_blink: got %b expected 0", blink); end
    vec_cnt++;
    if (mode_active !== M_STARTUP) begin err_cnt++; $display("FAIL reset_mode: got %0d expected %0d", mode_active, M_STARTUP); end
`ifdef COMPOSITOR_COLLISION_EN
    vec_cnt++;
    if (collision !== 6'b0) begin err_cnt++; $display("FAIL reset_collision: got %b expected 000000", collision); end
`endif
    rst = 1'b1;
    overlay_hit = 1'b0;
    text_hit = 1'b0;
    sprite_hit = 4'b0110;
    set_pix(5, 5, 1'b1);
  endtask

  task automatic test_startup_play();
    step(2);
    vec_cnt++;
    if (rgb !== 12'h000) begin err_cnt++; $display("FAIL startup_black: got %h expected %h", rgb, 12'h000); end
    vec_cnt++;
    if (mode_active !== M_STARTUP) begin err_cnt++; $display("FAIL startup_mode: got %0d expected %0d", mode_active, M_STARTUP); end
    set_pix(0, VV, 1'b0);
    step(1);
    vec_cnt++;
    if (frame_tick !== 1'b1) begin err_cnt++; $display("FAIL first_tick: got %b expected 1", frame_tick); end
    set_pix(0, 0, 1'b1);
    sprite_hit = 4'b0000;
    step(1);
    vec_cnt++;
    if (frame_tick !== 1'b0) begin err_cnt++; $display("FAIL tick_one_cycle: got %b expected 0", frame_tick); end
    vec_cnt++;
    if (mode_active !== M_PLAY) begin err_cnt++; $display("FAIL play_latched: got %0d expected %0d", mode_active, M_PLAY); end
    step(2);
    sprite_hit = 4'b0110;
    step(1);
    vec_cnt++;
    if (rgb !== 12'h000) begin err_cnt++; $display("FAIL latency_not_1: got %h expected %h", rgb, 12'h000); end
    step(1);
    vec_cnt++;
    if (rgb !== C1) begin err_cnt++; $display("FAIL latency_2_sprite1: got %h expected %h", rgb, C1); end
  endtask

  task automatic test_play_priority();
    for (int k = 0; k < 6; k++) begin
      sprite_hit = PV_HIT[k];
      sprite_en = PV_EN[k];
      overlay_hit = PV_OV[k];
      text_hit = PV_TX[k];
      step(2);
      vec_cnt++;
      if (rgb !== PV_EXP[k]) begin err_cnt++; $display("FAIL play_prio_%0d: got %h expected %h", k, rgb, PV_EXP[k]); end
    end
  endtask

  task automatic test_no_tearing();
    sprite_hit = 4'b0110;
    sprite_en = 4'b1111;
    overlay_hit = 1'b0;
    text_hit = 1'b0;
    set_pix(0, 200, 1'b1);
    mode_req = M_OVER;
    step(5);
    vec_cnt++;
    if (mode_active !== M_PLAY) begin err_cnt++; $display("FAIL no_tear_mode_mid: got %0d expected %0d", mode_active, M_PLAY); end
    vec_cnt++;
    if (rgb !== C1) begin err_cnt++; $display("FAIL no_tear_rgb_mid: got %h expected %h", rgb, C1); end
    set_pix(0, 300, 1'b1);
    mode_req = M_PLAY;
    step(5);
    frame_boundary();
    vec_cnt++;
    if (mode_active !== M_PLAY) begin err_cnt++; $display("FAIL no_tear_mode_after: got %0d expected %0d", mode_active, M_PLAY); end
    vec_cnt++;
    if (rgb !== C1) begin err_cnt++; $display("FAIL no_tear_rgb_after: got %h expected %h", rgb, C1); end
  endtask

  task automatic test_over();
    mode_req = M_OVER;
    frame_boundary();
    vec_cnt++;
    if (mode_active !== M_OVER) begin err_cnt++; $display("FAIL over_mode: got %0d expected %0d", mode_active, M_OVER); end
    sprite_hit = 4'b1111;
    text_hit = 1'b1;
    step(2);
    vec_cnt++;
    if (rgb !== 12'hFFF) begin err_cnt++; $display("FAIL over_text: got %h expected %h", rgb, 12'hFFF); end
    text_hit = 1'b0;
    step(2);
    vec_cnt++;
    if (rgb !== 12'h000) begin err_cnt++; $display("FAIL over_no_sprites: got %h expected %h", rgb, 12'h000); end
  endtask

  task automatic test_pause_blink();
    logic        exp_blink [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [11:0] exp_rgb   [4] = '{12'h731, 12'hFFF, 12'hFFF, 12'h731};
    mode_req = M_PAUSE;
    sprite_hit = 4'b0001;
    sprite_en = 4'b1111;
    overlay_hit = 1'b0;
    text_hit = 1'b1;
    frame_boundary();
    vec_cnt++;
    if (mode_active !== M_PAUSE) begin err_cnt++; $display("FAIL pause_mode: got %0d expected %0d", mode_active, M_PAUSE); end
    vec_cnt++;
    if (blink !== 1'b0) begin err_cnt++; $display("FAIL pause_entry_blink: got %b expected 0", blink); end
    vec_cnt++;
    if (rgb !== 12'h731) begin err_cnt++; $display("FAIL pause_entry_rgb: got %h expected %h", rgb, 12'h731); end
    for (int f = 0; f < 4; f++) begin
      frame_boundary();
      vec_cnt++;
      if (blink !== exp_blink[f]) begin err_cnt++; $display("FAIL pause_blink_f%0d: got %b expected %b", f, blink, exp_blink[f]); end
      vec_cnt++;
      if (rgb !== exp_rgb[f]) begin err_cnt++; $display("FAIL pause_rgb_f%0d: got %h expected %h", f, rgb, exp_rgb[f]); end
    end
    text_hit = 1'b0;
    sprite_hit = 4'b0000;
    overlay_hit = 1'b1;
    step(2);
    vec_cnt++;
    if (rgb !== 12'h777) begin err_cnt++; $display("FAIL pause_dim_overlay: got %h expected %h", rgb, 12'h777); end
  endtask

  task automatic test_video_off();
    int ticks;
    sprite_hit = 4'b1111;
    overlay_hit = 1'b1;
    text_hit = 1'b1;
    set_pix(100, 100, 1'b0);
    step(2);
    vec_cnt++;
    if (rgb !== 12'h000) begin err_cnt++; $display("FAIL video_off_black: got %h expected %h", rgb, 12'h000); end
    set_pix(0, VV - 1, 1'b1);
    step(1);
    vec_cnt++;
    if (frame_tick !== 1'b0) begin err_cnt++; $display("FAIL no_tick_last_line: got %b expected 0", frame_tick); end
    set_pix(0, VV, 1'b0);
    step(1);
    ticks = int'(frame_tick);
    for (int x = 1; x < 9; x++) begin
      set_pix(x, VV, 1'b0);
      step(1);
      ticks += int'(frame_tick);
    end
    vec_cnt++;
    if (ticks !== 1) begin err_cnt++; $display("FAIL ticks_per_frame: got %0d expected 1", ticks); end
  endtask

`ifdef COMPOSITOR_COLLISION_EN
  task automatic test_collision();
    sprite_hit = 4'b0000;
    sprite_en = 4'b1111;
    overlay_hit = 1'b0;
    text_hit = 1'b0;
    frame_boundary();
    set_pix(20, 20, 1'b1);
    sprite_hit = 4'b1001;
    step(1);
    sprite_hit = 4'b0000;
    step(2);
    frame_boundary();
    vec_cnt++;
    if (collision !== 6'b000100) begin err_cnt++; $display("FAIL collision_pair03: got %b expected 000100", collision); end
    frame_boundary();
    vec_cnt++;
    if (collision !== 6'b000000) begin err_cnt++; $display("FAIL collision_cleared: got %b expected 000000", collision); end
  endtask
`endif

  task automatic test_reset_midframe();
    mode_req = M_PLAY;
    sprite_hit = 4'b0001;
    sprite_en = 4'b1111;
    overlay_hit = 1'b0;
    text_hit = 1'b0;
    frame_boundary();
    vec_cnt++;
    if (rgb !== C0) begin err_cnt++; $display("FAIL pre_reset_play: got %h expected %h", rgb, C0); end
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    vec_cnt++;
    if (rgb !== 12'h000) begin err_cnt++; $display("FAIL midframe_reset_black: got %h expected %h", rgb, 12'h000); end
    vec_cnt++;
    if (mode_active !== M_STARTUP) begin err_cnt++; $display("FAIL midframe_reset_mode: got %0d expected %0d", mode_active, M_STARTUP); end
    step(2);
    vec_cnt++;
    if (rgb !== 12'h000) begin err_cnt++; $display("FAIL after_reset_startup: got %h expected %h", rgb, 12'h000); end
    text_hit = 1'b1;
    step(2);
    vec_cnt++;
    if (rgb !== 12'hFFF) begin err_cnt++; $display("FAIL after_reset_text: got %h expected %h", rgb, 12'hFFF); end
  endtask

  initial begin
    test_reset();
    test_startup_play();
    test_play_priority();
    test_no_tearing();
    test_over();
    test_pause_blink();
    test_video_off();
`ifdef COMPOSITOR_COLLISION_EN
    test_collision();
`endif
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
